// File: rtl/dec2bin_seq_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-binary converter.
// Used by dec2bin_seq and its per-digit correction cell bcd_sub3.
package dec2bin_seq_pkg;

    localparam int              BCD_DIGIT_W    = 4;
    localparam logic [3:0]      BCD_MAX_DIGIT  = 4'd9;
    localparam logic [3:0]      BCD_SUB_THRESH = 4'd8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/dec2bin_seq_bcd_sub3.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the digit is 8 or more.
// Purely combinational; instantiated once per digit by dec2bin_seq.
module bcd_sub3
    import dec2bin_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= BCD_SUB_THRESH) ? din - BCD_DIGIT_W'(3) : din;

endmodule

// File: rtl/dec2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble), one bit per clock.
// Optional invalid-digit detection is enabled by defining DEC2BIN_DIGIT_CHECK_EN.
module dec2bin_seq
    import dec2bin_seq_pkg::*;
#(
    parameter int DIGITS = 6,
    parameter int BIN_W  = 20
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic                          iStart,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] iBCD,
    output logic                          oBusy,
    output logic                          oDone,
    output logic [BIN_W-1:0]              oData,
    output logic                          oErr
);

    localparam int              BCD_W     = BCD_DIGIT_W * DIGITS;
    localparam int              SREG_W    = BCD_W + BIN_W;
    localparam int              CNT_W     = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    state_t            state, state_next;
    logic [SREG_W-1:0] sreg;
    logic [SREG_W-1:0] shifted;
    logic [BCD_W-1:0]  corr_bcd;
    logic [SREG_W-1:0] stepped;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              last_step;
    logic              err_flag;

    // One iteration: shift the whole register right, then correct every BCD digit.
    assign shifted = sreg >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_sub3 u_sub3 (
            .din  (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (corr_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign stepped   = {corr_bcd, shifted[BIN_W-1:0]};
    assign accept    = (state == ST_IDLE) && iStart;
    assign last_step = (state == ST_SHIFT) && (cnt == LAST_STEP);

    always_ff @(posedge iCLK) begin
        if (iRST) state <= ST_IDLE;
        else      state <= state_next;
    end

    // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (iStart) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_STEP) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        oBusy = (state == ST_SHIFT);
    end

    // NOTE: sequential state uses non-blocking '<='; sreg is reset too so a restart never sees stale bits.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sreg  <= '0;
            cnt   <= '0;
            oDone <= 1'b0;
            oData <= '0;
        end else begin
            oDone <= 1'b0;
            if (accept) begin
                sreg <= {iBCD, {BIN_W{1'b0}}};
                cnt  <= '0;
            end else if (state == ST_SHIFT) begin
                sreg <= stepped;
                cnt  <= cnt + 1'b1;
                if (last_step) begin
                    oDone <= 1'b1;
                    oData <= err_flag ? '0 : stepped[BIN_W-1:0];
                end
            end
        end
    end

`ifdef DEC2BIN_DIGIT_CHECK_EN
    logic bad_in;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad_in = bad_in | digit_invalid(iBCD[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    // The flag travels with the operand; oErr is updated only when a result is published.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            err_flag <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            if (accept)    err_flag <= bad_in;
            if (last_step) oErr     <= err_flag;
        end
    end
`else
    assign err_flag = 1'b0;
    assign oErr     = 1'b0;
`endif

endmodule

// File: tb/tb_dec2bin_seq.sv
// Self-checking bench for dec2bin_seq: directed handshake cases plus random operands
// checked against a decimal-arithmetic reference model.
module tb_dec2bin_seq;

    localparam int DIGITS = 6;
    localparam int BIN_W  = 20;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic              iStart;
    logic [23:0]       iBCD;
    logic              oBusy;
    logic              oDone;
    logic [BIN_W-1:0]  oData;
    logic              oErr;

    int n_checks = 0;
    int n_errors = 0;

    dec2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iStart (iStart),
        .iBCD   (iBCD),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oData  (oData),
        .oErr   (oErr)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the decimal value of the digits, computed with plain arithmetic.
    function automatic int bcd_value(input logic [23:0] b);
        int v = 0;
        int w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v += int'(b[i*4 +: 4]) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic logic has_bad(input logic [23:0] b);
        logic bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) if (b[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] exp_data(input logic [23:0] b);
`ifdef DEC2BIN_DIGIT_CHECK_EN
        if (has_bad(b)) return 32'd0;
`endif
        return 32'(bcd_value(b));
    endfunction

    function automatic logic [31:0] exp_err(input logic [23:0] b);
`ifdef DEC2BIN_DIGIT_CHECK_EN
        return {31'd0, has_bad(b)};
`else
        return 32'd0;
`endif
    endfunction

    // One conversion over a fixed window; optionally pokes an ignored iStart at cycle poke_k.
    task automatic run_conv(input logic [23:0] bcd, input int poke_k, input string tag);
        int busy_n = 0;
        int done_n = 0;
        int done_at = 0;
        logic [31:0] data_at = '0;
        logic [31:0] err_at  = '0;
        @(negedge iCLK);
        iBCD   = bcd;
        iStart = 1'b1;
        @(posedge iCLK);
        for (int k = 1; k <= 45; k++) begin
            @(negedge iCLK);
            if (k == poke_k) begin
                iStart = 1'b1;
                iBCD   = 24'h000042;
            end else begin
                iStart = 1'b0;
                iBCD   = $urandom;
            end
            busy_n += int'(oBusy);
            if (oDone) begin
                done_n++;
                if (done_n == 1) begin
                    done_at = k;
                    data_at = 32'(oData);
                    err_at  = 32'(oErr);
                end
            end
        end
        check({tag, ".busy_cycles"}, busy_n, BIN_W);
        check({tag, ".done_at"}, done_at, BIN_W + 1);
        check({tag, ".done_count"}, done_n, 1);
        check({tag, ".data"}, data_at, exp_data(bcd));
        check({tag, ".err"}, err_at, exp_err(bcd));
        check({tag, ".data_held"}, 32'(oData), exp_data(bcd));
    endtask

    initial begin
        int done_n;
        int d1_at, d2_at;
        logic [31:0] d1, d2;
        logic [23:0] r;

        iRST   = 1'b1;
        iStart = 1'b0;
        iBCD   = '0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("reset.busy", 32'(oBusy), 0);
        check("reset.done", 32'(oDone), 0);
        check("reset.data", 32'(oData), 0);
        check("reset.err",  32'(oErr),  0);
        iRST = 1'b0;

        run_conv(24'h123456, 0, "t1");
        check("t1.const", 32'(oData), 32'h1E240);
        run_conv(24'h999999, 0, "max");
        check("max.const", 32'(oData), 32'hF423F);
        run_conv(24'h000000, 0, "zero");
        run_conv(24'h000001, 0, "one");
        run_conv(24'h314159, 5, "poke");

        // Reset mid-conversion.
        @(negedge iCLK);
        iBCD   = 24'h777777;
        iStart = 1'b1;
        @(posedge iCLK);
        for (int k = 1; k <= 10; k++) begin
            @(negedge iCLK);
            iStart = 1'b0;
            if (k == 10) iRST = 1'b1;
        end
        @(negedge iCLK);
        check("rst.busy", 32'(oBusy), 0);
        check("rst.done", 32'(oDone), 0);
        check("rst.data", 32'(oData), 0);
        iRST   = 1'b0;
        done_n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge iCLK);
            done_n += int'(oDone);
        end
        check("rst.no_done", done_n, 0);
        run_conv(24'h000100, 0, "after_rst");

        // Back-to-back: iStart held high through the first oDone cycle.
        @(negedge iCLK);
        iBCD   = 24'h000250;
        iStart = 1'b1;
        @(posedge iCLK);
        done_n = 0;
        d1_at = 0; d2_at = 0; d1 = '0; d2 = '0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge iCLK);
            if (k == 2)  iBCD   = 24'h000017;
            if (k == 22) iStart = 1'b0;
            if (oDone) begin
                done_n++;
                if (done_n == 1) begin d1_at = k; d1 = 32'(oData); end
                if (done_n == 2) begin d2_at = k; d2 = 32'(oData); end
            end
        end
        check("b2b.count",   done_n, 2);
        check("b2b.first",   d1, 32'd250);
        check("b2b.second",  d2, 32'd17);
        check("b2b.spacing", d2_at - d1_at, BIN_W + 1);

`ifdef DEC2BIN_DIGIT_CHECK_EN
        run_conv(24'h00A000, 0, "bad_digit");
        check("bad_digit.err_const", 32'(oErr), 1);
        run_conv(24'h000123, 0, "good_after_bad");
        check("good_after_bad.err_const", 32'(oErr), 0);
`endif

        for (int n = 0; n < 8; n++) begin
            r = '0;
            for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
            run_conv(r, (n % 2 == 0) ? int'($urandom_range(2, 19)) : 0, $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
